// File: rtl/bpi_cycle_gen.sv
// Bus-cycle timing engine for an asynchronous parallel NOR flash.
// It sequences CE#/ADV#/OE#/WE#, the address and DQ through setup, strobe, hold and recovery.
module bpi_cycle_gen #(
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_RECOV = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EXECUTE,
  input  logic              CYCLE2,
  input  logic              READ,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_DATA,
  input  logic [DATA_W-1:0] DQ_IN,
  output logic              BUSY,
  output logic              RDY,
  output logic              LD_DAT,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [ADDR_W-1:0] FLASH_A,
  output logic [DATA_W-1:0] DQ_OUT,
  output logic              DQ_OE,
  output logic              FLASH_CE_B,
  output logic              FLASH_OE_B,
  output logic              FLASH_WE_B,
  output logic              FLASH_ADV_B
);

  if (T_SETUP < 1 || T_SETUP > 16) begin : g_bad_setup
    $error("T_SETUP must be in 1..16");
  end
  if (T_PULSE < 1 || T_PULSE > 16) begin : g_bad_pulse
    $error("T_PULSE must be in 1..16");
  end
  if (T_HOLD < 1 || T_HOLD > 16) begin : g_bad_hold
    $error("T_HOLD must be in 1..16");
  end
  if (T_RECOV < 1 || T_RECOV > 16) begin : g_bad_recov
    $error("T_RECOV must be in 1..16");
  end

  localparam logic [3:0] CntSetup = 4'(T_SETUP - 1);
  localparam logic [3:0] CntPulse = 4'(T_PULSE - 1);
  localparam logic [3:0] CntHold  = 4'(T_HOLD - 1);
  localparam logic [3:0] CntRecov = 4'(T_RECOV - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StRecov} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ld_dat_q, ld_dat_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_b_q, ce_b_d;
  logic              oe_b_q, oe_b_d;
  logic              we_b_q, we_b_d;
  logic              adv_b_q, adv_b_d;

  // State register (all outputs are registered alongside the FSM state).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      ld_dat_q  <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b1;
      dq_oe_q   <= 1'b0;
      ce_b_q    <= 1'b1;
      oe_b_q    <= 1'b1;
      we_b_q    <= 1'b1;
      adv_b_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      ld_dat_q  <= ld_dat_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      dq_oe_q   <= dq_oe_d;
      ce_b_q    <= ce_b_d;
      oe_b_q    <= oe_b_d;
      we_b_q    <= we_b_d;
      adv_b_q   <= adv_b_d;
    end
  end

  // Next-state logic: each timed state exits on the edge where the counter reads zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    write_d   = write_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    ld_dat_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 4'd0;
        if (EXECUTE) begin
          state_d = StSetup;
          cnt_d   = CntSetup;
          write_d = CYCLE2 | ~READ;
          addr_d  = CMD_ADDR;
          data_d  = CMD_DATA;
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StStrobe;
          cnt_d   = CntPulse;
        end
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          cnt_d   = CntHold;
          // Sample DQ while OE# is still low on the final strobe clock.
          if (!write_q) begin
            rd_data_d = DQ_IN;
            ld_dat_d  = 1'b1;
          end
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StRecov;
          cnt_d   = CntRecov;
        end
      end
      StRecov: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so pins change on the same edge as the state.
  always_comb begin
    busy_d  = (state_d != StIdle);
    rdy_d   = ~busy_d;
    ce_b_d  = ~((state_d == StSetup) | (state_d == StStrobe) | (state_d == StHold));
    adv_b_d = ~((state_q == StIdle) & (state_d == StSetup));
    oe_b_d  = ~((state_d == StStrobe) & ~write_d);
    we_b_d  = ~((state_d == StStrobe) & write_d);
    dq_oe_d = write_d & ~ce_b_d;
  end

  assign BUSY        = busy_q;
  assign RDY         = rdy_q;
  assign LD_DAT      = ld_dat_q;
  assign RD_DATA     = rd_data_q;
  assign FLASH_A     = addr_q;
  assign DQ_OUT      = data_q;
  assign DQ_OE       = dq_oe_q;
  assign FLASH_CE_B  = ce_b_q;
  assign FLASH_OE_B  = oe_b_q;
  assign FLASH_WE_B  = we_b_q;
  assign FLASH_ADV_B = adv_b_q;

endmodule

// File: tb/tb_bpi_cycle_gen.sv
// Self-checking bench for bpi_cycle_gen: directed vector table, corner sequences and a
// randomized run compared every clock against a cycle-position reference model.
module tb_bpi_cycle_gen;

  localparam int AW  = 23;
  localparam int DW  = 16;
  localparam int S   = 2;
  localparam int P   = 4;
  localparam int H   = 1;
  localparam int R   = 2;
  localparam int TOT = S + P + H + R;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          EXECUTE = 1'b0;
  logic          CYCLE2 = 1'b0;
  logic          READ = 1'b0;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [DW-1:0] CMD_DATA = '0;
  logic [DW-1:0] flash_val = '0;
  logic [DW-1:0] DQ_IN;
  logic          BUSY, RDY, LD_DAT, DQ_OE;
  logic [DW-1:0] RD_DATA, DQ_OUT;
  logic [AW-1:0] FLASH_A;
  logic          FLASH_CE_B, FLASH_OE_B, FLASH_WE_B, FLASH_ADV_B;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Flash model: drives valid data only while OE# is low.
  assign DQ_IN = FLASH_OE_B ? ~flash_val : flash_val;

  always #5 CLK = ~CLK;

  bpi_cycle_gen #(
    .ADDR_W(AW), .DATA_W(DW), .T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_RECOV(R)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EXECUTE(EXECUTE), .CYCLE2(CYCLE2), .READ(READ),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .DQ_IN(DQ_IN), .BUSY(BUSY), .RDY(RDY),
    .LD_DAT(LD_DAT), .RD_DATA(RD_DATA), .FLASH_A(FLASH_A), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE),
    .FLASH_CE_B(FLASH_CE_B), .FLASH_OE_B(FLASH_OE_B), .FLASH_WE_B(FLASH_WE_B),
    .FLASH_ADV_B(FLASH_ADV_B)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t is the clock position within a cycle (0 = idle, 1..TOT = busy).
  int            m_t = 0;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_rd = '0;
  logic          m_ld = 1'b0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_t <= 0; m_addr <= '0; m_data <= '0; m_rd <= '0; m_ld <= 1'b0;
    end else begin
      m_ld <= 1'b0;
      if (m_t == 0) begin
        if (EXECUTE) begin
          m_t <= 1; m_write <= CYCLE2 | ~READ; m_addr <= CMD_ADDR; m_data <= CMD_DATA;
        end
      end else begin
        if (m_t == S + P && !m_write) begin
          m_rd <= flash_val; m_ld <= 1'b1;
        end
        m_t <= (m_t == TOT) ? 0 : m_t + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      automatic bit busy   = (m_t != 0);
      automatic bit ce_on  = (m_t >= 1) && (m_t <= S + P + H);
      automatic bit strobe = (m_t > S) && (m_t <= S + P);
      chk("m_busy", 64'(BUSY), 64'(busy));
      chk("m_rdy", 64'(RDY), 64'(!busy));
      chk("m_ce_b", 64'(FLASH_CE_B), 64'(!ce_on));
      chk("m_adv_b", 64'(FLASH_ADV_B), 64'(m_t != 1));
      chk("m_oe_b", 64'(FLASH_OE_B), 64'(!(strobe && !m_write)));
      chk("m_we_b", 64'(FLASH_WE_B), 64'(!(strobe && m_write)));
      chk("m_dq_oe", 64'(DQ_OE), 64'(ce_on && m_write));
      chk("m_ld_dat", 64'(LD_DAT), 64'(m_ld));
      chk("m_rd_data", 64'(RD_DATA), 64'(m_rd));
      chk("m_flash_a", 64'(FLASH_A), 64'(m_addr));
      chk("m_dq_out", 64'(DQ_OUT), 64'(m_data));
      chk("bus_conflict", 64'(!FLASH_OE_B && (!FLASH_WE_B || DQ_OE)), 64'(0));
    end
  end

  typedef struct {
    logic          rd;
    logic          c2;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] flash;
    int            busy_n;
    int            we_n;
    int            oe_n;
    int            ld_n;
    int            dqoe_n;
    int            first_strobe;
    logic [DW-1:0] rd_exp;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input int k);
    int idx, busy_n, we_n, oe_n, ld_n, dqoe_n, first_strobe;
    logic [AW-1:0] a_seen;
    busy_n = 0; we_n = 0; oe_n = 0; ld_n = 0; dqoe_n = 0; first_strobe = 0; a_seen = '0;
    @(negedge CLK);
    EXECUTE = 1'b1; READ = v.rd; CYCLE2 = v.c2; CMD_ADDR = v.addr; CMD_DATA = v.data;
    flash_val = v.flash;
    @(negedge CLK);
    EXECUTE = 1'b0;
    idx = 1;
    while (BUSY && idx < 100) begin
      busy_n++;
      if (!FLASH_WE_B) we_n++;
      if (!FLASH_OE_B) oe_n++;
      if (LD_DAT) ld_n++;
      if (DQ_OE) dqoe_n++;
      if (first_strobe == 0 && (!FLASH_WE_B || !FLASH_OE_B)) first_strobe = idx;
      if (idx == 1) a_seen = FLASH_A;
      idx++;
      @(negedge CLK);
    end
    chk($sformatf("v%0d_busy_clocks", k), 64'(busy_n), 64'(v.busy_n));
    chk($sformatf("v%0d_we_clocks", k), 64'(we_n), 64'(v.we_n));
    chk($sformatf("v%0d_oe_clocks", k), 64'(oe_n), 64'(v.oe_n));
    chk($sformatf("v%0d_ld_pulses", k), 64'(ld_n), 64'(v.ld_n));
    chk($sformatf("v%0d_dq_oe_clocks", k), 64'(dqoe_n), 64'(v.dqoe_n));
    chk($sformatf("v%0d_first_strobe", k), 64'(first_strobe), 64'(v.first_strobe));
    chk($sformatf("v%0d_flash_a", k), 64'(a_seen), 64'(v.addr));
    chk($sformatf("v%0d_rd_data", k), 64'(RD_DATA), 64'(v.rd_exp));
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 23'h012345, 16'h00E8, 16'h1111, 9, 4, 0, 0, 7, 3, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 23'h7FFFFF, 16'h5555, 16'hBEEF, 9, 0, 4, 1, 0, 3, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 23'h000001, 16'hA5A5, 16'h2222, 9, 4, 0, 0, 7, 3, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 23'h000000, 16'hFFFF, 16'h1234, 9, 0, 4, 1, 0, 3, 16'h1234};

    // Reset held for three clocks.
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rdy", 64'(RDY), 64'(1));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_strobes", 64'({FLASH_CE_B, FLASH_OE_B, FLASH_WE_B, FLASH_ADV_B}), 64'(4'hF));
    chk("rst_dq_oe", 64'(DQ_OE), 64'(0));
    chk("rst_rd_data", 64'(RD_DATA), 64'(0));
    RST_N = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Reset during the strobe of a write.
    begin
      int n;
      @(negedge CLK);
      EXECUTE = 1'b1; READ = 1'b0; CYCLE2 = 1'b0; CMD_ADDR = 23'h00ABCD; CMD_DATA = 16'h4242;
      @(negedge CLK);
      EXECUTE = 1'b0;
      n = 0;
      while (FLASH_WE_B && n < 20) begin @(negedge CLK); n++; end
      chk("rst_mid_reached_strobe", 64'(FLASH_WE_B), 64'(0));
      RST_N = 1'b0;
      @(negedge CLK);
      chk("rst_mid_we_ce", 64'({FLASH_WE_B, FLASH_CE_B}), 64'(2'b11));
      chk("rst_mid_busy", 64'(BUSY), 64'(0));
      chk("rst_mid_ld", 64'(LD_DAT), 64'(0));
      RST_N = 1'b1;
    end

    // EXECUTE held high: back-to-back cycles, address changed mid-cycle.
    begin
      int n, gap;
      @(negedge CLK);
      EXECUTE = 1'b1; READ = 1'b1; CYCLE2 = 1'b0; CMD_ADDR = 23'h000100; flash_val = 16'h0F0F;
      @(negedge CLK);
      CMD_ADDR = 23'h000200;
      @(negedge CLK);
      chk("b2b_addr_held", 64'(FLASH_A), 64'(23'h000100));
      n = 0;
      while (BUSY && n < 40) begin @(negedge CLK); n++; end
      gap = 0;
      while (!BUSY && gap < 40) begin @(negedge CLK); gap++; end
      chk("b2b_rdy_gap", 64'(gap), 64'(1));
      chk("b2b_new_addr", 64'(FLASH_A), 64'(23'h000200));
      EXECUTE = 1'b0;
      n = 0;
      while (BUSY && n < 40) begin @(negedge CLK); n++; end
      chk("b2b_ends", 64'(BUSY), 64'(0));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      EXECUTE   = ($urandom_range(0, 3) != 0);
      READ      = $urandom_range(0, 1) == 1;
      CYCLE2    = ($urandom_range(0, 4) == 0);
      CMD_ADDR  = AW'($urandom);
      CMD_DATA  = DW'($urandom);
      flash_val = DW'($urandom);
      RST_N     = ($urandom_range(0, 199) != 0);
    end
    @(negedge CLK);
    RST_N = 1'b1; EXECUTE = 1'b0;
    repeat (TOT + 2) @(negedge CLK);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpi_cycle_gen.md
Name: bpi_cycle_gen

Overview:
- Bus-cycle timing engine directly downstream of the BPI control FSM.
- Consumes the FSM's EXECUTE/CYCLE2 strobes plus the latched command address/data.
- Drives the asynchronous parallel-flash pins (CE#, OE#, WE#, ADV#, A, DQ) with programmable setup/pulse/hold/recovery timing.
- Returns the BUSY, RDY and LD_DAT handshakes the FSM waits on.

Parameters:
- ADDR_W, 23, flash address width.
- DATA_W, 16, flash data width.
- T_SETUP, 2, clocks from CE#/address valid to strobe assertion (1..16).
- T_PULSE, 4, clocks OE#/WE# held low (1..16).
- T_HOLD, 1, clocks CE#/address/data held after strobe release (1..16).
- T_RECOV, 2, idle clocks after CE# release before RDY returns (1..16).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous active-low reset.
- EXECUTE  in  1  level request from the FSM; sampled only in IDLE.
- CYCLE2  in  1  second cycle of a two-cycle command; forces a write cycle.
- READ  in  1  1 = read cycle, 0 = write cycle; ignored when CYCLE2=1.
- CMD_ADDR  in  ADDR_W  flash address for the cycle.
- CMD_DATA  in  DATA_W  write data for the cycle.
- DQ_IN  in  DATA_W  flash data bus, input side.
- BUSY  out  1  cycle in progress.
- RDY  out  1  engine idle, able to accept EXECUTE.
- LD_DAT  out  1  one-clock pulse: RD_DATA was just updated.
- RD_DATA  out  DATA_W  captured read data.
- FLASH_A  out  ADDR_W  flash address.
- DQ_OUT  out  DATA_W  flash write data.
- DQ_OE  out  1  DQ output enable, active high.
- FLASH_CE_B  out  1  chip enable, active low.
- FLASH_OE_B  out  1  output enable, active low.
- FLASH_WE_B  out  1  write enable, active low.
- FLASH_ADV_B  out  1  address valid, active low.

Behaviour:
- Registering and reset
  - All outputs are registered.
  - Reset (RST_N=0 at a CLK edge), including mid-cycle, forces on the next edge: state IDLE, BUSY=0, RDY=1, LD_DAT=0, RD_DATA=0, FLASH_A=0, DQ_OUT=0, DQ_OE=0, CE_B/OE_B/WE_B/ADV_B=1, counter=0.
- States: IDLE, SETUP, STROBE, HOLD, RECOV.
- Counter
  - 4-bit down-counter, loaded with T_x-1 on entry to each timed state.
  - The state exits on the edge where the counter = 0.
  - Each state therefore lasts exactly T_x clocks.
- IDLE
  - RDY=1, BUSY=0.
  - If EXECUTE=1: latch the operation, FLASH_A<=CMD_ADDR, DQ_OUT<=CMD_DATA, then go to SETUP.
  - Latched operation: write if CYCLE2=1 or READ=0, otherwise read.
- SETUP
  - BUSY=1, RDY=0, CE_B=0.
  - ADV_B=0 during the first SETUP clock only.
  - DQ_OE=1 for a write.
  - Goes to STROBE.
- STROBE
  - Read: OE_B=0. Write: WE_B=0 and DQ_OE=1.
  - On a read, the last STROBE clock captures DQ_IN into RD_DATA, and LD_DAT pulses high for exactly 1 clock, coincident with the new RD_DATA.
  - Goes to HOLD.
- HOLD
  - OE_B=WE_B=1; CE_B, FLASH_A and DQ_OE are held.
  - Goes to RECOV.
- RECOV
  - CE_B=1, DQ_OE=0, BUSY=1.
  - Goes to IDLE.
- Timing summary
  - BUSY is high for exactly T_SETUP+T_PULSE+T_HOLD+T_RECOV clocks, starting the edge after EXECUTE is sampled.
  - RDY = !BUSY at all times.
- Input changes
  - EXECUTE, READ, CYCLE2, CMD_ADDR and CMD_DATA are ignored outside IDLE.
  - Changes mid-cycle have no effect.
- Back-to-back cycles
  - If EXECUTE is still high on the first IDLE clock, a new cycle starts, with exactly 1 RDY-high clock between cycles.
  - The FSM drops EXECUTE on seeing BUSY, so this case occurs only on a genuine new request.
- LD_DAT never asserts on write cycles.
- Bus conflict: OE_B and WE_B are never low simultaneously; DQ_OE=1 never coincides with OE_B=0.
- Parameter outside 1..16: elaboration error.

Test Plan:
- Reset, then hold RST_N=0 for 3 clocks → RDY=1, BUSY=0, CE_B/OE_B/WE_B/ADV_B=1, DQ_OE=0, RD_DATA=0.
- Write cycle with defaults: EXECUTE=1 for 1 clock, READ=0, CMD_ADDR=0x012345, CMD_DATA=0x00E8 →
  - BUSY high 9 clocks; WE_B low clocks 3–6; FLASH_A=0x012345, DQ_OUT=0x00E8 with DQ_OE=1 clocks 1–7; LD_DAT never asserts.
- Read cycle with defaults, READ=1, flash model drives DQ_IN=0xBEEF during STROBE →
  - OE_B low 4 clocks; LD_DAT single pulse on the last STROBE clock; RD_DATA=0xBEEF; DQ_OE stays 0.
- CYCLE2=1 with READ=1 → executes a write (WE_B pulses, OE_B stays 1).
- Assert RST_N=0 during STROBE of a write → WE_B and CE_B return to 1 on the next edge; BUSY=0; no LD_DAT.
- EXECUTE held high continuously → consecutive cycles separated by exactly 1 RDY clock; changing CMD_ADDR mid-cycle does not alter FLASH_A until the next IDLE sample.
